// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - b_i with borrow-out and signed overflow, valid/ready on both sides
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_o,
  output logic             v
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic b_q, b_d, bo_q, bo_d, v_q, v_d, xm_q, xm_d, ym_q, ym_d;
  logic dbit, bn;
  // The minuend register doubles as the difference accumulator: each
  // consumed x bit frees the MSB slot that receives the new difference bit.
  assign dbit = xs_q[0] ^ ys_q[0] ^ b_q;
  assign bn = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d = d_q;
  assign b_o = bo_q;
  assign v = v_q;
  // Next-state: load in IDLE, one full-subtractor step per RUN cycle, release in DONE
  always_comb begin
    state_d = state_q;
    xs_d = xs_q;
    ys_d = ys_q;
    d_d = d_q;
    cnt_d = cnt_q;
    b_d = b_q;
    bo_d = bo_q;
    v_d = v_q;
    xm_d = xm_q;
    ym_d = ym_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        xs_d = x;
        ys_d = y;
        b_d = b_i;
        cnt_d = '0;
        xm_d = x[WIDTH-1];
        ym_d = y[WIDTH-1];
      end
      RUN: begin
        xs_d = {dbit, xs_q[WIDTH-1:1]};
        ys_d = {1'b0, ys_q[WIDTH-1:1]};
        b_d = bn;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d = {dbit, xs_q[WIDTH-1:1]};
          bo_d = bn;
          v_d = (xm_q ^ ym_q) & (xm_q ^ dbit);
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xs_q <= '0;
      ys_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      b_q <= 1'b0;
      bo_q <= 1'b0;
      v_q <= 1'b0;
      xm_q <= 1'b0;
      ym_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q <= xs_d;
      ys_q <= ys_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      b_q <= b_d;
      bo_q <= bo_d;
      v_q <= v_d;
      xm_q <= xm_d;
      ym_q <= ym_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for 4- and 8-bit serial subtractors
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, b_i = 1'b0;
  logic [3:0] x = '0, y = '0;
  logic in_ready, out_valid, b_o, v;
  logic [3:0] d;
  logic in_valid8 = 1'b0, out_ready8 = 1'b0, b_i8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic in_ready8, out_valid8, b_o8, v8;
  logic [7:0] d8;
  logic [5:0] q4[$];
  logic [9:0] q8[$];
  logic [5:0] e4;
  logic [9:0] e8;
  int checks = 0, errors = 0;
  logic active;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .b_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .b_o(b_o), .v(v)
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8), .b_i(b_i8),
    .out_valid(out_valid8), .out_ready(out_ready8), .d(d8), .b_o(b_o8), .v(v8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from the true signed result range
  task automatic model(input int w, input int xu, input int yu, input int b,
                       output int dd, output bit bo, output bit vv);
    int u, sx, sy, s;
    u = xu - yu - b;
    bo = u < 0;
    dd = u & ((1 << w) - 1);
    sx = xu >= (1 << (w - 1)) ? xu - (1 << w) : xu;
    sy = yu >= (1 << (w - 1)) ? yu - (1 << w) : yu;
    s = sx - sy - b;
    vv = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endtask

  task automatic issue4(input logic [3:0] xa, input logic [3:0] ya, input logic ba, input logic [5:0] e);
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !in_ready; i++) begin @(posedge clk); #1; end
    if (!in_ready) begin
      check("in_ready4_timeout", 0, 1);
      return;
    end
    x = xa; y = ya; b_i = ba; in_valid = 1'b1;
    q4.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] xa, input logic [7:0] ya, input logic ba, input logic [9:0] e);
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !in_ready8; i++) begin @(posedge clk); #1; end
    if (!in_ready8) begin
      check("in_ready8_timeout", 0, 1);
      return;
    end
    x8 = xa; y8 = ya; b_i8 = ba; in_valid8 = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && (q4.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    #1;
    check(name, q4.size() + q8.size(), 0);
  endtask

  task automatic wait_valid4(output int k);
    k = 1;
    for (int i = 0; i < 50 && !out_valid; i++) begin @(posedge clk); #1; k++; end
  endtask

  initial begin
    int k, dd;
    bit bo, vv;
    logic [3:0] rx, ry;
    logic [7:0] rx8, ry8;
    logic rb;
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          checks++;
          if (q4.size() == 0) begin
            errors++;
            $display("FAIL result4: unexpected d=%0h b_o=%0b v=%0b", d, b_o, v);
          end else begin
            e4 = q4.pop_front();
            if ({d, b_o, v} !== e4) begin
              errors++;
              $display("FAIL result4: got d=%0h b_o=%0b v=%0b expected d=%0h b_o=%0b v=%0b",
                       d, b_o, v, e4[5:2], e4[1], e4[0]);
            end
          end
        end
      end
      forever begin
        @(negedge clk);
        if (!rst && out_valid8 && out_ready8) begin
          checks++;
          if (q8.size() == 0) begin
            errors++;
            $display("FAIL result8: unexpected d=%0h b_o=%0b v=%0b", d8, b_o8, v8);
          end else begin
            e8 = q8.pop_front();
            if ({d8, b_o8, v8} !== e8) begin
              errors++;
              $display("FAIL result8: got d=%0h b_o=%0b v=%0b expected d=%0h b_o=%0b v=%0b",
                       d8, b_o8, v8, e8[9:2], e8[1], e8[0]);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_d", d, 0);
    check("reset_b_o", b_o, 0);
    check("reset_v", v, 0);
    out_ready = 1'b1;
    issue4(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b1});
    wait_valid4(k);
    check("latency", k, 5);
    issue4(4'd5, 4'd3, 1'b0, {4'h2, 1'b0, 1'b0});
    issue4(4'd3, 4'd9, 1'b0, {4'hA, 1'b1, 1'b1});
    issue4(4'd0, 4'd0, 1'b1, {4'hF, 1'b1, 1'b0});
    drain("drain_directed");
    out_ready = 1'b0;
    issue4(4'd12, 4'd5, 1'b1, {4'h6, 1'b0, 1'b1});
    wait_valid4(k);
    check("bp_out_valid", out_valid, 1);
    x = 4'd1; y = 4'd1; b_i = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_d", d, 4'h6);
      check("bp_flags", {b_o, v}, 2'b01);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("drain_bp");
    repeat (8) @(posedge clk);
    #1 check("bp_no_extra", out_valid, 0);
    out_ready = 1'b0;
    issue4(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b1});
    wait_valid4(k);
    check("pre_async_valid", out_valid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    q4.delete();
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_out_valid", out_valid, 0);
    check("async_d", d, 0);
    check("async_b_o", b_o, 0);
    check("async_v", v, 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    issue4(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b1});
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    q4.delete();
    @(posedge clk); #1 rst = 1'b0;
    check("midrun_in_ready", in_ready, 1);
    k = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; k += int'(out_valid); end
    check("midrun_no_valid", k, 0);
    issue4(4'd7, 4'd7, 1'b0, {4'h0, 1'b0, 1'b0});
    drain("drain_midrun");
    active = 1'b1;
    fork
      begin
        fork
          for (int n = 0; n < 40; n++) begin
            rx = 4'($urandom_range(0, 15)); ry = 4'($urandom_range(0, 15)); rb = 1'($urandom_range(0, 1));
            model(4, int'(rx), int'(ry), int'(rb), dd, bo, vv);
            issue4(rx, ry, rb, {4'(dd), bo, vv});
          end
          for (int n = 0; n < 40; n++) begin
            rx8 = 8'($urandom_range(0, 255)); ry8 = 8'($urandom_range(0, 255)); rb = 1'($urandom_range(0, 1));
            model(8, int'(rx8), int'(ry8), int'(rb), dd, bo, vv);
            issue8(rx8, ry8, rb, {8'(dd), bo, vv});
          end
        join
        drain("drain_stream");
        active = 1'b0;
      end
      while (active) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        out_ready8 = 1'($urandom_range(0, 1));
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
